// File: rtl/alu_sequencer.sv
// rtl/alu_sequencer.sv - four-state register-file sequencer driving an external combinational ALU
// Accept -> READ operands -> EXEC capture -> WB write-back; host writes land only while idle.
module alu_sequencer #(
  parameter int W   = 8,
  parameter int OPW = 3
) (
  input  logic           Clk,
  input  logic           Reset,
  input  logic [8:0]     Instr,
  input  logic           InstrValid,
  output logic           InstrReady,
  output logic [W-1:0]   AluA,
  output logic [W-1:0]   AluB,
  output logic [OPW-1:0] AluOp,
  input  logic [W-1:0]   AluOut,
  input  logic           HostWrEn,
  input  logic [2:0]     HostWrAddr,
  input  logic [W-1:0]   HostWrData,
  input  logic [2:0]     RegRdAddr,
  output logic [W-1:0]   RegRdData,
  output logic           Done,
  output logic [W-1:0]   Result,
  output logic           Zero
);

  typedef enum logic [1:0] {IDLE, READ, EXEC, WB} state_t;

  state_t         state_q, state_d;
  logic [OPW-1:0] op_q;
  logic [2:0]     rd_q, rs_q;
  logic [W-1:0]   regs_q [8];
  logic [W-1:0]   alu_a_q, alu_b_q;
  logic [OPW-1:0] alu_op_q;
  logic [W-1:0]   res_q;
  logic [W-1:0]   result_q;
  logic           zero_q;
  logic           accept;

  assign accept = InstrValid && (state_q == IDLE);

  always_comb begin
    state_d    = state_q;
    InstrReady = 1'b0;
    Done       = 1'b0;
    case (state_q)
      IDLE: begin
        InstrReady = 1'b1;
        if (InstrValid) state_d = READ;
      end
      READ: state_d = EXEC;
      EXEC: state_d = WB;
      WB: begin
        Done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Host writes and write-back are mutually exclusive by state, so one array port suffices.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      for (int i = 0; i < 8; i++) regs_q[i] <= '0;
      op_q     <= '0;
      rd_q     <= '0;
      rs_q     <= '0;
      alu_a_q  <= '0;
      alu_b_q  <= '0;
      alu_op_q <= '0;
      res_q    <= '0;
      result_q <= '0;
      zero_q   <= 1'b0;
    end else begin
      if (accept) begin
        op_q <= OPW'(Instr[8:6]);
        rd_q <= Instr[5:3];
        rs_q <= Instr[2:0];
      end
      if ((state_q == IDLE) && HostWrEn) regs_q[HostWrAddr] <= HostWrData;
      if (state_q == READ) begin
        alu_a_q  <= regs_q[rd_q];
        alu_b_q  <= regs_q[rs_q];
        alu_op_q <= op_q;
      end
      if (state_q == EXEC) res_q <= AluOut;
      if (state_q == WB) begin
        regs_q[rd_q] <= res_q;
        result_q     <= res_q;
        zero_q       <= (res_q == '0);
      end
    end
  end

  assign AluA      = alu_a_q;
  assign AluB      = alu_b_q;
  assign AluOp     = alu_op_q;
  assign RegRdData = regs_q[RegRdAddr];
  assign Result    = result_q;
  assign Zero      = zero_q;

endmodule

// File: tb/tb_alu_sequencer.sv
// tb/tb_alu_sequencer.sv - scoreboard bench for alu_sequencer with an add/sub ALU model
module tb_alu_sequencer;
  localparam int W = 8;

  logic         Clk = 1'b0;
  logic         Reset = 1'b1;
  logic [8:0]   Instr = '0;
  logic         InstrValid = 1'b0;
  logic         InstrReady;
  logic [W-1:0] AluA, AluB, AluOut;
  logic [2:0]   AluOp;
  logic         HostWrEn = 1'b0;
  logic [2:0]   HostWrAddr = '0;
  logic [W-1:0] HostWrData = '0;
  logic [2:0]   RegRdAddr = '0;
  logic [W-1:0] RegRdData;
  logic         Done;
  logic [W-1:0] Result;
  logic         Zero;

  int n_cmp = 0;
  int n_bad = 0;
  logic [W-1:0] model_regs [8];
  logic [W-1:0] exp_q [$];
  logic [W-1:0] exec_a, exec_b;

  always #5 Clk = ~Clk;

  function automatic logic [W-1:0] alu_model(input logic [W-1:0] a, input logic [W-1:0] b,
                                             input logic [2:0] op);
    case (op)
      3'b000:  return a + b;
      3'b001:  return a - b;
      default: return a ^ b;
    endcase
  endfunction

  assign AluOut = alu_model(AluA, AluB, AluOp);

  alu_sequencer #(.W(W), .OPW(3)) dut (
    .Clk(Clk), .Reset(Reset), .Instr(Instr), .InstrValid(InstrValid), .InstrReady(InstrReady),
    .AluA(AluA), .AluB(AluB), .AluOp(AluOp), .AluOut(AluOut),
    .HostWrEn(HostWrEn), .HostWrAddr(HostWrAddr), .HostWrData(HostWrData),
    .RegRdAddr(RegRdAddr), .RegRdData(RegRdData), .Done(Done), .Result(Result), .Zero(Zero)
  );

  task automatic host_write(input logic [2:0] a, input logic [W-1:0] d);
    HostWrEn = 1'b1; HostWrAddr = a; HostWrData = d;
    @(negedge Clk);
    HostWrEn = 1'b0;
    model_regs[a] = d;
  endtask

  // Issues one instruction (optionally with a same-cycle host write to rs) and checks it via the scoreboard.
  task automatic run_instr(input logic [2:0] op, input logic [2:0] rd, input logic [2:0] rs,
                           input bit hw, input logic [W-1:0] hw_data);
    logic [W-1:0] exp;
    int lat;
    bit seen;
    Instr = {op, rd, rs}; InstrValid = 1'b1;
    for (int i = 0; i < 10 && !InstrReady; i++) @(negedge Clk);
    n_cmp++;
    if (InstrReady !== 1'b1) begin n_bad++; $display("FAIL ready_wait: InstrReady=%b required 1", InstrReady); end
    if (hw) begin
      HostWrEn = 1'b1; HostWrAddr = rs; HostWrData = hw_data;
      model_regs[rs] = hw_data;
    end
    exp = alu_model(model_regs[rd], model_regs[rs], op);
    exp_q.push_back(exp);
    model_regs[rd] = exp;
    @(negedge Clk);
    InstrValid = 1'b0; HostWrEn = 1'b0;
    lat = 1; seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (lat == 2) begin exec_a = AluA; exec_b = AluB; end
      if (Done === 1'b1) begin seen = 1'b1; break; end
      lat++;
      @(negedge Clk);
    end
    n_cmp++;
    if (!seen || lat != 3) begin n_bad++; $display("FAIL latency: got %0d (seen=%0b) required 3", lat, seen); end
    if (seen) begin
      exp = exp_q.pop_front();
      @(negedge Clk);
      n_cmp++;
      if (Result !== exp) begin n_bad++; $display("FAIL result: got %h required %h", Result, exp); end
      n_cmp++;
      if (Zero !== (exp == '0)) begin n_bad++; $display("FAIL zero: got %b required %b", Zero, exp == '0); end
      n_cmp++;
      if (Done !== 1'b0) begin n_bad++; $display("FAIL done_pulse: got %b required 0", Done); end
      RegRdAddr = rd; #1;
      n_cmp++;
      if (RegRdData !== exp) begin n_bad++; $display("FAIL reg_wb: reg%0d=%h required %h", rd, RegRdData, exp); end
    end else begin
      exp_q.delete();
    end
  endtask

  task automatic test_reset();
    repeat (2) @(negedge Clk);
    n_cmp++;
    if ({AluA, AluB, AluOp, Result, Zero, Done} !== '0) begin
      n_bad++; $display("FAIL reset_outs: A=%h B=%h Op=%h R=%h Z=%b D=%b required all 0", AluA, AluB, AluOp, Result, Zero, Done);
    end
    for (int i = 0; i < 8; i++) begin
      RegRdAddr = 3'(i); #1;
      n_cmp++;
      if (RegRdData !== '0) begin n_bad++; $display("FAIL reset_reg%0d: got %h required 00", i, RegRdData); end
      model_regs[i] = '0;
    end
    @(negedge Clk);
    Reset = 1'b0; #1;
    n_cmp++;
    if (InstrReady !== 1'b1) begin n_bad++; $display("FAIL ready_after_reset: got %b required 1", InstrReady); end
    @(negedge Clk);
  endtask

  task automatic test_add();
    host_write(3'd1, 8'h05);
    host_write(3'd2, 8'h03);
    run_instr(3'b000, 3'd1, 3'd2, 1'b0, '0);
  endtask

  task automatic test_wrap();
    host_write(3'd3, 8'hFF);
    host_write(3'd4, 8'h01);
    run_instr(3'b000, 3'd3, 3'd4, 1'b0, '0);
  endtask

  task automatic test_same_reg();
    host_write(3'd5, 8'h07);
    run_instr(3'b001, 3'd5, 3'd5, 1'b0, '0);
    n_cmp++;
    if (exec_a !== 8'h07 || exec_b !== 8'h07) begin
      n_bad++; $display("FAIL same_reg_ops: A=%h B=%h required 07/07", exec_a, exec_b);
    end
  endtask

  task automatic test_host_and_accept();
    run_instr(3'b000, 3'd1, 3'd2, 1'b1, 8'h20);
    n_cmp++;
    if (exec_b !== 8'h20) begin n_bad++; $display("FAIL host_same_cycle: B=%h required 20", exec_b); end
  endtask

  task automatic test_back_to_back();
    int acc[$];
    int dones;
    bit pend;
    logic [W-1:0] exp, pend_v;
    host_write(3'd6, 8'd10);
    host_write(3'd7, 8'd20);
    Instr = {3'b000, 3'd6, 3'd7}; InstrValid = 1'b1;
    dones = 0; pend = 1'b0; pend_v = '0;
    for (int c = 0; c < 24; c++) begin
      if (pend) begin
        n_cmp++;
        if (Result !== pend_v) begin n_bad++; $display("FAIL b2b_result: got %h required %h", Result, pend_v); end
        pend = 1'b0;
      end
      if (Done === 1'b1) begin
        dones++;
        if (exp_q.size() > 0) begin pend_v = exp_q.pop_front(); pend = 1'b1; end
      end
      if (acc.size() == 1 && c == acc[0] + 1) Instr = {3'b000, 3'd6, 3'd6};
      if (acc.size() == 1 && c == acc[0] + 2) begin HostWrEn = 1'b1; HostWrAddr = 3'd0; HostWrData = 8'hAA; end
      if (acc.size() == 1 && c == acc[0] + 3) HostWrEn = 1'b0;
      if (acc.size() == 2 && c == acc[1] + 1) InstrValid = 1'b0;
      if (InstrValid && InstrReady && acc.size() < 2) begin
        acc.push_back(c);
        exp = alu_model(model_regs[Instr[5:3]], model_regs[Instr[2:0]], Instr[8:6]);
        exp_q.push_back(exp);
        model_regs[Instr[5:3]] = exp;
      end
      @(negedge Clk);
    end
    InstrValid = 1'b0;
    n_cmp++;
    if (acc.size() != 2 || acc[1] - acc[0] != 4) begin
      n_bad++; $display("FAIL b2b_spacing: accepts=%0d gap=%0d required 2 and 4", acc.size(), acc.size() == 2 ? acc[1] - acc[0] : -1);
    end
    n_cmp++;
    if (dones != 2) begin n_bad++; $display("FAIL b2b_dones: got %0d required 2", dones); end
    RegRdAddr = 3'd0; #1;
    n_cmp++;
    if (RegRdData !== model_regs[0]) begin n_bad++; $display("FAIL host_ignored: reg0=%h required %h", RegRdData, model_regs[0]); end
    RegRdAddr = 3'd6; #1;
    n_cmp++;
    if (RegRdData !== model_regs[6]) begin n_bad++; $display("FAIL b2b_reg6: got %h required %h", RegRdData, model_regs[6]); end
    exp_q.delete();
    @(negedge Clk);
  endtask

  task automatic test_reset_mid();
    int dones;
    Instr = {3'b000, 3'd1, 3'd2}; InstrValid = 1'b1;
    for (int i = 0; i < 10 && !InstrReady; i++) @(negedge Clk);
    @(negedge Clk);
    InstrValid = 1'b0;
    @(negedge Clk);
    Reset = 1'b1; #1;
    n_cmp++;
    if ({AluA, AluB, AluOp, Result, Zero, Done} !== '0) begin
      n_bad++; $display("FAIL mid_reset_outs: A=%h B=%h Op=%h R=%h Z=%b D=%b required all 0", AluA, AluB, AluOp, Result, Zero, Done);
    end
    @(negedge Clk);
    Reset = 1'b0; #1;
    n_cmp++;
    if (InstrReady !== 1'b1) begin n_bad++; $display("FAIL mid_reset_ready: got %b required 1", InstrReady); end
    for (int i = 0; i < 8; i++) model_regs[i] = '0;
    dones = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge Clk);
      if (Done === 1'b1) dones++;
    end
    n_cmp++;
    if (dones != 0) begin n_bad++; $display("FAIL mid_reset_done: pulses=%0d required 0", dones); end
    RegRdAddr = 3'd1; #1;
    n_cmp++;
    if (RegRdData !== '0) begin n_bad++; $display("FAIL mid_reset_rd: reg1=%h required 00", RegRdData); end
  endtask

  initial begin
    test_reset();
    test_add();
    test_wrap();
    test_same_reg();
    test_host_and_accept();
    test_back_to_back();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/alu_sequencer.md
ALU_SEQUENCER -- requirements
Module: alu_sequencer

Interface
REQ-001 SHALL have parameter W, default 8, datapath and register width.
REQ-002 SHALL have parameter OPW, default 3, ALU opcode width.
REQ-003 SHALL have port Clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port Reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port Instr  input  9  instruction {op[8:6], rd[5:3], rs[2:0]}.
REQ-006 SHALL have port InstrValid  input  1  Instr is presented.
REQ-007 SHALL have port InstrReady  output  1  sequencer accepts Instr this cycle.
REQ-008 SHALL have port AluA  output  W  ALU operand A (registered).
REQ-009 SHALL have port AluB  output  W  ALU operand B (registered).
REQ-010 SHALL have port AluOp  output  OPW  ALU opcode (registered).
REQ-011 SHALL have port AluOut  input  W  combinational ALU result for AluA/AluB/AluOp.
REQ-012 SHALL have port HostWrEn  input  1  host register-file write strobe.
REQ-013 SHALL have port HostWrAddr  input  3  host write address.
REQ-014 SHALL have port HostWrData  input  W  host write data.
REQ-015 SHALL have port RegRdAddr  input  3  debug read address.
REQ-016 SHALL have port RegRdData  output  W  combinational read of reg[RegRdAddr].
REQ-017 SHALL have port Done  output  1  one-cycle pulse on writeback.
REQ-018 SHALL have port Result  output  W  last written-back value (held).
REQ-019 SHALL have port Zero  output  1  Result == 0, updated at writeback only.

Function
REQ-020 SHALL contain 8 internal registers of W bits, reg[0..7], none hardwired.
REQ-021 SHALL implement FSM states IDLE, READ, EXEC, WB.
REQ-022 SHALL drive InstrReady = 1 only in IDLE; accept occurs when InstrValid && InstrReady at a rising edge.
REQ-023 On accept SHALL latch op, rd, rs and move IDLE -> READ; otherwise stay in IDLE.
REQ-024 In READ SHALL register AluA <= reg[rd], AluB <= reg[rs], AluOp <= op; move to EXEC.
REQ-025 In EXEC SHALL capture AluOut into an internal result register; move to WB.
REQ-026 In WB SHALL write reg[rd] <= captured value, Result <= captured value, Zero <= (value == 0), Done = 1; move to IDLE.
REQ-027 Accept-to-Done latency SHALL be 3 cycles; throughput one instruction per 4 cycles; Done never asserted outside WB.
REQ-028 rd == rs SHALL read the same register for both operands; no special casing.
REQ-029 Arithmetic is owned by the ALU; sequencer SHALL pass AluOut through untruncated and unmodified (wrap-around is the ALU's W-bit result).
REQ-030 Host writes SHALL take effect only when state is IDLE; in any other state HostWrEn is ignored.
REQ-031 Host write and instruction accept in the same IDLE cycle SHALL both occur; READ of the next cycle sees the host-written value.
REQ-032 Instr and InstrValid changes while not in IDLE SHALL have no effect.
REQ-033 AluA, AluB, AluOp SHALL hold their values from READ until the next READ.

Reset
REQ-034 Reset assertion SHALL immediately force state IDLE, all reg[] = 0, AluA = AluB = 0, AluOp = 0, Result = 0, Zero = 0, Done = 0.
REQ-035 Reset mid-operation (READ/EXEC/WB) SHALL abort the instruction with no writeback and no Done pulse.
REQ-036 InstrReady SHALL be 1 in the first cycle after Reset deasserts.

Verification
REQ-037 Bench SHALL use an ALU model where op 000 = A + B mod 2^W and op 001 = A - B mod 2^W.
REQ-038 Host write reg1=8'h05, reg2=8'h03; issue {000,1,2} -> Done 3 cycles after accept, reg1 = 8'h08, Result = 8'h08, Zero = 0.
REQ-039 reg3=8'hFF, reg4=8'h01; issue {000,3,4} -> reg3 = 8'h00, Zero = 1 (wrap-around).
REQ-040 reg5=8'h07; issue {001,5,5} -> AluA = AluB = 8'h07, reg5 = 8'h00, Zero = 1.
REQ-041 Hold InstrValid high with two instructions back-to-back -> second accepted only when InstrReady returns in IDLE, 4 cycles apart; HostWrEn pulsed during EXEC leaves reg[] unchanged.
REQ-042 Assert Reset during EXEC -> no Done, reg[rd] = 0, all outputs at reset values, InstrReady = 1 after release.
